// File: rtl/eight_req_priority_arbiter.sv
// Fixed-priority arbiter for 8 requesters (req[7] highest).
// A grant is locked to its owner until the owner releases it or the hold
// limit revokes it. A revoked owner is masked for one arbitration so that
// a lower-priority requester can get through.
module eight_req_priority_arbiter #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout_pulse,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_p0, state_d;
  logic [7:0]         gnt_p0, gnt_d;
  logic [2:0]         id_p0, id_d;
  logic [7:0]         mask_p0, mask_d;
  logic [CNT_W-1:0]   cnt_p0, cnt_d;
  logic               tp_p0, tp_d;
  logic [7:0]         elig;

  // Highest set index of v; 0 when v is zero (same coding as gnt_id).
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign elig = req & ~mask_p0;

  // Next-state and next-output decode; release wins over timeout.
  always_comb begin
    state_d = state_p0;
    gnt_d   = gnt_p0;
    id_d    = id_p0;
    mask_d  = mask_p0;
    cnt_d   = cnt_p0;
    tp_d    = 1'b0;
    case (state_p0)
      IDLE: begin
        // The mask only ever blocks a single arbitration.
        mask_d = 8'h00;
        gnt_d  = 8'h00;
        id_d   = 3'd0;
        cnt_d  = '0;
        if (|elig) begin
          id_d    = prio_enc(elig);
          gnt_d   = 8'(1) << id_d;
          cnt_d   = CNT_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[id_p0]) begin
          gnt_d   = 8'h00;
          id_d    = 3'd0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_p0 == CNT_W'(MAX_HOLD)) begin
          mask_d  = gnt_p0;
          gnt_d   = 8'h00;
          id_d    = 3'd0;
          cnt_d   = '0;
          tp_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_p0 + CNT_W'(1);
        end
      end
      default: begin
        gnt_d   = 8'h00;
        id_d    = 3'd0;
        mask_d  = 8'h00;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      gnt_p0   <= 8'h00;
      id_p0    <= 3'd0;
      mask_p0  <= 8'h00;
      cnt_p0   <= '0;
      tp_p0    <= 1'b0;
    end else begin
      state_p0 <= state_d;
      gnt_p0   <= gnt_d;
      id_p0    <= id_d;
      mask_p0  <= mask_d;
      cnt_p0   <= cnt_d;
      tp_p0    <= tp_d;
    end
  end

  assign gnt           = gnt_p0;
  assign gnt_id        = id_p0;
  assign gnt_valid     = |gnt_p0;
  assign timeout_pulse = tp_p0;
  assign busy          = (state_p0 == GRANT);

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));
  a_valid : assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid == (|gnt));
  a_id : assert property (@(posedge clk) disable iff (!rst_n)
    gnt_id == prio_enc(gnt));
  a_hold_range : assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid |-> (cnt_p0 != '0 && cnt_p0 <= CNT_W'(MAX_HOLD)));
  a_hold_run : assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_valid && $past(gnt_valid)) |->
      (gnt == $past(gnt) && cnt_p0 == $past(cnt_p0) + CNT_W'(1)));
  a_tp_drop : assert property (@(posedge clk) disable iff (!rst_n)
    timeout_pulse |-> (gnt == 8'h00));

endmodule

// File: tb/tb_eight_req_priority_arbiter.sv
// Scoreboard bench for eight_req_priority_arbiter.
module tb_eight_req_priority_arbiter;

  localparam int MAXH = 15;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout_pulse;
  logic       busy;

  eight_req_priority_arbiter #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .gnt           (gnt),
    .gnt_id        (gnt_id),
    .gnt_valid     (gnt_valid),
    .timeout_pulse (timeout_pulse),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] id;
    logic       vld;
    logic       tp;
    logic       bsy;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owner index (-1 = none), hold count, masked index.
  int   m_owner = -1;
  int   m_hold  = 0;
  int   m_mask  = -1;
  logic m_tp    = 1'b0;
  int   run_len;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, want);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_mask  = -1;
    m_tp    = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    int pick;
    pick = -1;
    m_tp = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < 8; i++) begin
        if (r[i] && i != m_mask) pick = i;
      end
      m_mask = -1;
      if (pick >= 0) begin
        m_owner = pick;
        m_hold  = 1;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
      m_hold  = 0;
    end else if (m_hold == MAXH) begin
      m_mask  = m_owner;
      m_owner = -1;
      m_hold  = 0;
      m_tp    = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.g   = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    e.id  = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    e.vld = (m_owner >= 0);
    e.bsy = (m_owner >= 0);
    e.tp  = m_tp;
    return e;
  endfunction

  // Apply req for one edge, predict, then compare after the edge.
  task automatic drive_cycle(input logic [7:0] r);
    exp_t e;
    req = r;
    model_step(r);
    sbq.push_back(model_out());
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("gnt",       32'(gnt),           32'(e.g));
    chk("gnt_id",    32'(gnt_id),        32'(e.id));
    chk("gnt_valid", 32'(gnt_valid),     32'(e.vld));
    chk("timeout",   32'(timeout_pulse), 32'(e.tp));
    chk("busy",      32'(busy),          32'(e.bsy));
  endtask

  task automatic check_idle_now(input string tag);
    chk({tag, "_gnt"},   32'(gnt),           32'h0);
    chk({tag, "_id"},    32'(gnt_id),        32'h0);
    chk({tag, "_vld"},   32'(gnt_valid),     32'h0);
    chk({tag, "_tp"},    32'(timeout_pulse), 32'h0);
    chk({tag, "_busy"},  32'(busy),          32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    model_reset();
    #1;
    check_idle_now("rst");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) begin
      drive_cycle(8'h00);
      chk("idle_busy", 32'(busy), 32'h0);
    end

    // Priority pick and release.
    drive_cycle(8'b0101_0010);
    chk("t2_gnt40", 32'(gnt), 32'h40);
    chk("t2_id6",   32'(gnt_id), 32'd6);
    for (int i = 0; i < 3; i++) drive_cycle(8'b0101_0010);
    chk("t2_still40", 32'(gnt), 32'h40);
    drive_cycle(8'b0001_0010);
    chk("t2_gap", 32'(gnt), 32'h0);
    drive_cycle(8'b0001_0010);
    chk("t2_gnt10", 32'(gnt), 32'h10);
    chk("t2_id4",   32'(gnt_id), 32'd4);
    drive_cycle(8'h00);
    drive_cycle(8'h00);

    // No preemption.
    for (int i = 0; i < 3; i++) drive_cycle(8'h08);
    chk("t3_gnt08", 32'(gnt), 32'h08);
    for (int i = 0; i < 3; i++) drive_cycle(8'h88);
    chk("t3_nopre", 32'(gnt), 32'h08);
    drive_cycle(8'h80);
    chk("t3_gap", 32'(gnt), 32'h0);
    drive_cycle(8'h80);
    chk("t3_gnt80", 32'(gnt), 32'h80);
    drive_cycle(8'h00);
    drive_cycle(8'h00);

    // Timeout with masking, two requesters.
    run_len = 0;
    for (int i = 0; i < MAXH; i++) begin
      drive_cycle(8'h81);
      if (gnt == 8'h80) run_len++;
    end
    chk("t4_len80", 32'(run_len), 32'(MAXH));
    drive_cycle(8'h81);
    chk("t4_tp",     32'(timeout_pulse), 32'h1);
    chk("t4_drop",   32'(gnt), 32'h0);
    drive_cycle(8'h81);
    chk("t4_gnt01",  32'(gnt), 32'h01);
    chk("t4_tp_off", 32'(timeout_pulse), 32'h0);
    run_len = 1;
    for (int i = 0; i < MAXH - 1; i++) begin
      drive_cycle(8'h81);
      if (gnt == 8'h01) run_len++;
    end
    chk("t4_len01", 32'(run_len), 32'(MAXH));
    drive_cycle(8'h81);
    chk("t4_tp2", 32'(timeout_pulse), 32'h1);
    drive_cycle(8'h81);
    chk("t4_back80", 32'(gnt), 32'h80);
    drive_cycle(8'h00);
    drive_cycle(8'h00);

    // Timeout, single requester: two idle cycles before regrant.
    run_len = 0;
    for (int i = 0; i < MAXH; i++) begin
      drive_cycle(8'h04);
      if (gnt == 8'h04) run_len++;
    end
    chk("t5_len04", 32'(run_len), 32'(MAXH));
    drive_cycle(8'h04);
    chk("t5_tp",   32'(timeout_pulse), 32'h1);
    chk("t5_idle1", 32'(gnt), 32'h0);
    drive_cycle(8'h04);
    chk("t5_idle2", 32'(gnt), 32'h0);
    drive_cycle(8'h04);
    chk("t5_regnt", 32'(gnt), 32'h04);
    drive_cycle(8'h00);
    drive_cycle(8'h00);

    // Asynchronous reset in the middle of a grant.
    for (int i = 0; i < 3; i++) drive_cycle(8'hFF);
    chk("t6_gnt80", 32'(gnt), 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle_now("arst");
    @(posedge clk);
    #1;
    check_idle_now("arst_hold");
    #2;
    rst_n = 1'b1;
    drive_cycle(8'hFF);
    chk("t6_first80", 32'(gnt), 32'h80);
    chk("t6_id7",     32'(gnt_id), 32'd7);
    drive_cycle(8'h00);
    drive_cycle(8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
